// File: rtl/relu_maxpool.sv
// relu_maxpool: streaming ReLU followed by a 2x2 / stride-2 signed max-pool.
// Consumes a row-major M x M feature map (M = n-k+1), one element per accepted
// cycle, and emits one pooled value per 2x2 window using a half-row line buffer.
// Odd trailing row/column are counted but never pooled.
//
// Ports:
//   clk_i        in  1  clock, rising edge
//   rst_i        in  1  synchronous active-high reset
//   en_i         in  1  stage enable; when low, input is ignored and state holds
//   data_i       in  N  signed feature-map element
//   val_i        in  1  data_i valid (accepted only with en_i)
//   pool_o       out N  pooled result (always >= 0), holds between strobes
//   val_pool_o   out 1  one-cycle strobe, pool_o valid
//   done_pool_o  out 1  one-cycle strobe, end of frame
module relu_maxpool #(
  parameter int n = 4,
  parameter int k = 3,
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic signed [N-1:0] data_i,
  input  logic                val_i,
  output logic signed [N-1:0] pool_o,
  output logic                val_pool_o,
  output logic                done_pool_o
);

  localparam int unsigned M   = n - k + 1;
  localparam int unsigned P   = M / 2;
  localparam int unsigned CW  = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned JW  = (P > 1) ? $clog2(P) : 1;
  // Line buffer rounded up to a power of two so the pair index never needs a range check.
  localparam int unsigned LBD = 2 ** JW;

  // Reject maps too small to pool and nonsensical fixed-point formats.
  if ((n - k + 1) < 2 || Q > N) begin : g_bad_params
    $error("relu_maxpool: requires n-k+1 >= 2 and Q <= N");
  end

  logic [CW-1:0]       col;
  logic [CW-1:0]       row;
  logic signed [N-1:0] hold;
  logic signed [N-1:0] lb [LBD];

  logic                accept;
  logic signed [N-1:0] relu;
  logic signed [N-1:0] hmax;
  logic signed [N-1:0] vmax;
  logic [JW-1:0]       j;
  logic                col_last;
  logic                row_last;

  // Datapath: ReLU, horizontal max against the held even-column value,
  // vertical max against the line-buffer entry for this column pair.
  always_comb begin
    accept   = en_i & val_i;
    relu     = data_i[N-1] ? '0 : data_i;
    hmax     = (hold > relu) ? hold : relu;
    j        = JW'(col >> 1);
    vmax     = (lb[j] > hmax) ? lb[j] : hmax;
    col_last = (col == CW'(M - 1));
    row_last = (row == CW'(M - 1));
  end

  // Position counters, horizontal hold register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col         <= '0;
      row         <= '0;
      hold        <= '0;
      pool_o      <= '0;
      val_pool_o  <= 1'b0;
      done_pool_o <= 1'b0;
    end else begin
      val_pool_o  <= 1'b0;
      done_pool_o <= 1'b0;
      if (accept) begin
        if (!col[0]) begin
          hold <= relu;
        end else if (row[0]) begin
          // Odd row, odd column: bottom-right of a window completes here.
          pool_o     <= vmax;
          val_pool_o <= 1'b1;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        done_pool_o <= col_last & row_last;
      end
    end
  end

  // Line buffer: written on even rows, always ahead of the odd-row read, so no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept && col[0] && !row[0]) begin
      lb[j] <= hmax;
    end
  end

endmodule
